core_lsu: RTL and testbench

Parametrised load/store stage for the core pipeline, between the execute-side `m` stage and the writeback `w` stage. It issues word-aligned accesses over a request/grant + read-response bus that may insert wait states, and it stalls upstream until the access completes. It aligns and sign-extends load data, detects misaligned accesses, raises an access fault on a bus timeout, and holds the result in an output register until writeback accepts it.

---
 rtl/core_lsu.sv | 277 +++++++++++++++++++++++++++
 tb/tb_core_lsu.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
// Load/store stage between execute (m) and writeback (w): issues word-aligned
// bus accesses, aligns/extends load data, and reports misalign and bus-timeout faults.
module core_lsu #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_m_valid,
    output logic              o_m_ready_c,
    input  logic              i_m_mem_ren,
    input  logic              i_m_mem_wen,
    input  logic [2:0]        i_m_mem_type,
    input  logic [ADDR_W-1:0] i_m_addr,
    input  logic [31:0]       i_m_rs2,
    input  logic [31:0]       i_m_result,
    input  logic [4:0]        i_m_rd,
    input  logic              i_m_reg_wen,
    output logic              o_bus_req,
    input  logic              i_bus_gnt,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [31:0]       o_bus_wdata,
    output logic [3:0]        o_bus_bytemask,
    input  logic              i_bus_rvalid,
    input  logic [31:0]       i_bus_rdata,
    output logic              o_w_valid,
    input  logic              i_w_ready,
    output logic [31:0]       o_w_data,
    output logic [4:0]        o_w_rd,
    output logic              o_w_reg_wen,
    output logic              o_w_exc,
    output logic [3:0]        o_w_cause,
    output logic [ADDR_W-1:0] o_w_badaddr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    logic [1:0]        r_state,        w_nxt_state;
    logic [CNT_W-1:0]  r_cnt,          w_nxt_cnt;
    logic              r_dead,         w_nxt_dead;
    logic              r_store,        w_nxt_store;
    logic [2:0]        r_type,         w_nxt_type;
    logic [ADDR_W-1:0] r_addr,         w_nxt_addr;
    logic              r_bus_req,      w_nxt_bus_req;
    logic [31:0]       r_bus_wdata,    w_nxt_bus_wdata;
    logic [3:0]        r_bus_bytemask, w_nxt_bus_bytemask;
    logic              r_w_valid,      w_nxt_w_valid;
    logic [31:0]       r_w_data,       w_nxt_w_data;
    logic [4:0]        r_w_rd,         w_nxt_w_rd;
    logic              r_w_reg_wen,    w_nxt_w_reg_wen;
    logic              r_w_exc,        w_nxt_w_exc;
    logic [3:0]        r_w_cause,      w_nxt_w_cause;
    logic [ADDR_W-1:0] r_w_badaddr,    w_nxt_w_badaddr;

    logic        w_accept;
    logic        w_m_mem;
    logic        w_m_misal;
    logic        w_timeout;
    logic        w_dead_now;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_mask;
    logic [31:0] w_ld_shift;
    logic [31:0] w_ld_data;
    logic        w_finish;
    logic        w_fault;
    logic [31:0] w_fin_data;

    assign o_m_ready_c = ~i_flush & ((r_state == S_IDLE) | ((r_state == S_HOLD) & i_w_ready));
    assign w_accept    = i_m_valid & o_m_ready_c;
    assign w_m_mem     = i_m_mem_ren | i_m_mem_wen;
    assign w_m_misal   = ((i_m_mem_type[1:0] == 2'b01) & i_m_addr[0])
                       | (i_m_mem_type[1] & (i_m_addr[1:0] != 2'b00));
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_dead_now  = r_dead | i_flush;

    // Store lane replication and byte enables
    always_comb begin
        w_st_data = i_m_rs2;
        w_st_mask = 4'b1111;
        case (i_m_mem_type[1:0])
            2'b00: begin
                w_st_data = {4{i_m_rs2[7:0]}};
                w_st_mask = 4'b0001 << i_m_addr[1:0];
            end
            2'b01: begin
                w_st_data = {2{i_m_rs2[15:0]}};
                w_st_mask = 4'b0011 << i_m_addr[1:0];
            end
            default: ;
        endcase
    end

    // Load alignment and sign/zero extension
    assign w_ld_shift = i_bus_rdata >> {r_addr[1:0], 3'b000};
    always_comb begin
        w_ld_data = w_ld_shift;
        case (r_type[1:0])
            2'b00:   w_ld_data = {{24{~r_type[2] & w_ld_shift[7]}}, w_ld_shift[7:0]};
            2'b01:   w_ld_data = {{16{~r_type[2] & w_ld_shift[15]}}, w_ld_shift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        w_nxt_state        = r_state;
        w_nxt_cnt          = r_cnt;
        w_nxt_dead         = r_dead;
        w_nxt_store        = r_store;
        w_nxt_type         = r_type;
        w_nxt_addr         = r_addr;
        w_nxt_bus_req      = r_bus_req;
        w_nxt_bus_wdata    = r_bus_wdata;
        w_nxt_bus_bytemask = r_bus_bytemask;
        w_nxt_w_valid      = r_w_valid;
        w_nxt_w_data       = r_w_data;
        w_nxt_w_rd         = r_w_rd;
        w_nxt_w_reg_wen    = r_w_reg_wen;
        w_nxt_w_exc        = r_w_exc;
        w_nxt_w_cause      = r_w_cause;
        w_nxt_w_badaddr    = r_w_badaddr;
        w_finish           = 1'b0;
        w_fault            = 1'b0;
        w_fin_data         = '0;

        case (r_state)
            S_REQ: begin
                if (i_bus_gnt) begin
                    w_nxt_bus_req = 1'b0;
                    if (r_store) begin
                        w_finish = 1'b1;
                    end else begin
                        w_nxt_state = S_RESP;
                        w_nxt_cnt   = '0;
                        w_nxt_dead  = w_dead_now;
                    end
                end else if (w_timeout) begin
                    w_nxt_bus_req = 1'b0;
                    w_fault       = 1'b1;
                end else begin
                    w_nxt_cnt  = r_cnt + CNT_W'(1);
                    w_nxt_dead = w_dead_now;
                end
            end
            S_RESP: begin
                if (i_bus_rvalid) begin
                    w_finish   = 1'b1;
                    w_fin_data = w_ld_data;
                end else if (w_timeout) begin
                    w_fault = 1'b1;
                end else begin
                    w_nxt_cnt  = r_cnt + CNT_W'(1);
                    w_nxt_dead = w_dead_now;
                end
            end
            S_HOLD: begin
                if (i_flush | i_w_ready) begin
                    w_nxt_state   = S_IDLE;
                    w_nxt_w_valid = 1'b0;
                end
            end
            default: ;
        endcase

        // A flushed access still completes on the bus but is never presented
        if (w_finish | w_fault) begin
            if (w_dead_now) begin
                w_nxt_state = S_IDLE;
                w_nxt_dead  = 1'b0;
            end else begin
                w_nxt_state     = S_HOLD;
                w_nxt_w_valid   = 1'b1;
                w_nxt_w_data    = w_fin_data;
                w_nxt_w_exc     = w_fault;
                w_nxt_w_cause   = w_fault ? (r_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT) : 4'd0;
                w_nxt_w_badaddr = w_fault ? r_addr : '0;
                w_nxt_w_reg_wen = r_w_reg_wen & ~w_fault;
            end
        end

        if (w_accept) begin
            w_nxt_dead      = 1'b0;
            w_nxt_cnt       = '0;
            w_nxt_store     = i_m_mem_wen;
            w_nxt_type      = i_m_mem_type;
            w_nxt_addr      = i_m_addr;
            w_nxt_w_rd      = i_m_rd;
            w_nxt_w_exc     = 1'b0;
            w_nxt_w_cause   = 4'd0;
            w_nxt_w_badaddr = '0;
            w_nxt_w_data    = '0;
            if (!w_m_mem) begin
                w_nxt_state     = S_HOLD;
                w_nxt_w_valid   = 1'b1;
                w_nxt_w_data    = i_m_result;
                w_nxt_w_reg_wen = i_m_reg_wen;
            end else if (w_m_misal) begin
                w_nxt_state     = S_HOLD;
                w_nxt_w_valid   = 1'b1;
                w_nxt_w_exc     = 1'b1;
                w_nxt_w_cause   = i_m_mem_wen ? CAUSE_ST_MIS : CAUSE_LD_MIS;
                w_nxt_w_badaddr = i_m_addr;
                w_nxt_w_reg_wen = 1'b0;
            end else begin
                w_nxt_state        = S_REQ;
                w_nxt_w_valid      = 1'b0;
                w_nxt_bus_req      = 1'b1;
                w_nxt_bus_wdata    = w_st_data;
                w_nxt_bus_bytemask = w_st_mask;
                w_nxt_w_reg_wen    = i_m_reg_wen & ~i_m_mem_wen;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_dead         <= 1'b0;
            r_store        <= 1'b0;
            r_type         <= 3'd0;
            r_addr         <= '0;
            r_bus_req      <= 1'b0;
            r_bus_wdata    <= 32'd0;
            r_bus_bytemask <= 4'd0;
            r_w_valid      <= 1'b0;
            r_w_data       <= 32'd0;
            r_w_rd         <= 5'd0;
            r_w_reg_wen    <= 1'b0;
            r_w_exc        <= 1'b0;
            r_w_cause      <= 4'd0;
            r_w_badaddr    <= '0;
        end else begin
            r_state        <= w_nxt_state;
            r_cnt          <= w_nxt_cnt;
            r_dead         <= w_nxt_dead;
            r_store        <= w_nxt_store;
            r_type         <= w_nxt_type;
            r_addr         <= w_nxt_addr;
            r_bus_req      <= w_nxt_bus_req;
            r_bus_wdata    <= w_nxt_bus_wdata;
            r_bus_bytemask <= w_nxt_bus_bytemask;
            r_w_valid      <= w_nxt_w_valid;
            r_w_data       <= w_nxt_w_data;
            r_w_rd         <= w_nxt_w_rd;
            r_w_reg_wen    <= w_nxt_w_reg_wen;
            r_w_exc        <= w_nxt_w_exc;
            r_w_cause      <= w_nxt_w_cause;
            r_w_badaddr    <= w_nxt_w_badaddr;
        end
    end

    assign o_bus_req      = r_bus_req;
    assign o_bus_we       = r_store;
    assign o_bus_addr     = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_bus_wdata    = r_bus_wdata;
    assign o_bus_bytemask = r_bus_bytemask;
    assign o_w_valid      = r_w_valid;
    assign o_w_data       = r_w_data;
    assign o_w_rd         = r_w_rd;
    assign o_w_reg_wen    = r_w_reg_wen;
    assign o_w_exc        = r_w_exc;
    assign o_w_cause      = r_w_cause;
    assign o_w_badaddr    = r_w_badaddr;

endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu: pass-through, loads, stores, misalign, timeout, flush, reset.
module tb_core_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_flush, i_m_valid, o_m_ready_c, i_m_mem_ren, i_m_mem_wen;
    logic [2:0]  i_m_mem_type;
    logic [31:0] i_m_addr, i_m_rs2, i_m_result;
    logic [4:0]  i_m_rd;
    logic        i_m_reg_wen;
    logic        o_bus_req, i_bus_gnt, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_bytemask;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        o_w_valid, i_w_ready;
    logic [31:0] o_w_data;
    logic [4:0]  o_w_rd;
    logic        o_w_reg_wen, o_w_exc;
    logic [3:0]  o_w_cause;
    logic [31:0] o_w_badaddr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    core_lsu #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
        .i_m_valid(i_m_valid), .o_m_ready_c(o_m_ready_c),
        .i_m_mem_ren(i_m_mem_ren), .i_m_mem_wen(i_m_mem_wen), .i_m_mem_type(i_m_mem_type),
        .i_m_addr(i_m_addr), .i_m_rs2(i_m_rs2), .i_m_result(i_m_result),
        .i_m_rd(i_m_rd), .i_m_reg_wen(i_m_reg_wen),
        .o_bus_req(o_bus_req), .i_bus_gnt(i_bus_gnt), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_bytemask(o_bus_bytemask),
        .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
        .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data),
        .o_w_rd(o_w_rd), .o_w_reg_wen(o_w_reg_wen), .o_w_exc(o_w_exc),
        .o_w_cause(o_w_cause), .o_w_badaddr(o_w_badaddr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic ren, input logic wen, input logic [2:0] typ,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [31:0] res, input logic [4:0] rd);
        i_m_valid    = 1'b1;
        i_m_mem_ren  = ren;
        i_m_mem_wen  = wen;
        i_m_mem_type = typ;
        i_m_addr     = addr;
        i_m_rs2      = rs2;
        i_m_result   = res;
        i_m_rd       = rd;
        i_m_reg_wen  = 1'b1;
    endtask

    task automatic drop_op;
        i_m_valid   = 1'b0;
        i_m_mem_ren = 1'b0;
        i_m_mem_wen = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; i_flush = 1'b0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
        i_bus_rdata = 32'd0; i_w_ready = 1'b1; i_m_mem_type = 3'd0; i_m_addr = 32'd0;
        i_m_rs2 = 32'd0; i_m_result = 32'd0; i_m_rd = 5'd0; i_m_reg_wen = 1'b0;
        drop_op();
        repeat (2) tick();
        n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", o_bus_req); end
        n_checks++; if (o_w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_valid: got %b want 0", o_w_valid); end
        n_checks++; if (o_w_exc !== 1'b0) begin n_fail++; $display("FAIL reset_w_exc: got %b want 0", o_w_exc); end
        n_checks++; if (o_w_cause !== 4'd0) begin n_fail++; $display("FAIL reset_w_cause: got %0d want 0", o_w_cause); end
        n_checks++; if (o_w_data !== 32'd0) begin n_fail++; $display("FAIL reset_w_data: got %h want 0", o_w_data); end
        n_checks++; if (o_m_ready_c !== 1'b1) begin n_fail++; $display("FAIL reset_m_ready: got %b want 1", o_m_ready_c); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough;
        logic [31:0] vals [4];
        vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002;
        vals[2] = 32'h3333_0003; vals[3] = 32'h4444_0004;
        i_w_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, vals[i], 5'(i + 1));
            #1;
            n_checks++; if (o_m_ready_c !== 1'b1) begin n_fail++; $display("FAIL pt_m_ready[%0d]: got %b want 1", i, o_m_ready_c); end
            tick();
            n_checks++; if (o_w_valid !== 1'b1) begin n_fail++; $display("FAIL pt_w_valid[%0d]: got %b want 1", i, o_w_valid); end
            n_checks++; if (o_w_data !== vals[i]) begin n_fail++; $display("FAIL pt_w_data[%0d]: got %h want %h", i, o_w_data, vals[i]); end
            n_checks++; if (o_w_rd !== 5'(i + 1)) begin n_fail++; $display("FAIL pt_w_rd[%0d]: got %0d want %0d", i, o_w_rd, i + 1); end
            n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL pt_bus_req[%0d]: got %b want 0", i, o_bus_req); end
        end
        drop_op();
        tick();
        n_checks++; if (o_w_valid !== 1'b0) begin n_fail++; $display("FAIL pt_drain: got %b want 0", o_w_valid); end
    endtask

    task automatic test_load;
        logic [31:0] addrs [2];
        logic [2:0]  types [2];
        logic [31:0] exps  [2];
        addrs[0] = 32'h103; types[0] = 3'b000; exps[0] = 32'hFFFF_FF80;
        addrs[1] = 32'h102; types[1] = 3'b101; exps[1] = 32'h0000_80FF;
        for (int k = 0; k < 2; k++) begin
            drive_op(1'b1, 1'b0, types[k], addrs[k], 32'd0, 32'd0, 5'(10 + k));
            tick();
            drop_op();
            n_checks++; if (o_bus_req !== 1'b1) begin n_fail++; $display("FAIL ld_bus_req[%0d]: got %b want 1", k, o_bus_req); end
            n_checks++; if (o_bus_addr !== 32'h100) begin n_fail++; $display("FAIL ld_bus_addr[%0d]: got %h want 100", k, o_bus_addr); end
            n_checks++; if (o_bus_we !== 1'b0) begin n_fail++; $display("FAIL ld_bus_we[%0d]: got %b want 0", k, o_bus_we); end
            n_checks++; if (o_m_ready_c !== 1'b0) begin n_fail++; $display("FAIL ld_m_ready[%0d]: got %b want 0", k, o_m_ready_c); end
            i_bus_gnt = 1'b1;
            tick();
            i_bus_gnt = 1'b0;
            n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL ld_req_drop[%0d]: got %b want 0", k, o_bus_req); end
            n_checks++; if (o_w_valid !== 1'b0) begin n_fail++; $display("FAIL ld_early_valid[%0d]: got %b want 0", k, o_w_valid); end
            i_bus_rvalid = 1'b1; i_bus_rdata = 32'h80FF_1234;
            tick();
            i_bus_rvalid = 1'b0;
            n_checks++; if (o_w_valid !== 1'b1) begin n_fail++; $display("FAIL ld_w_valid[%0d]: got %b want 1", k, o_w_valid); end
            n_checks++; if (o_w_data !== exps[k]) begin n_fail++; $display("FAIL ld_w_data[%0d]: got %h want %h", k, o_w_data, exps[k]); end
            n_checks++; if (o_w_rd !== 5'(10 + k)) begin n_fail++; $display("FAIL ld_w_rd[%0d]: got %0d want %0d", k, o_w_rd, 10 + k); end
            n_checks++; if (o_w_reg_wen !== 1'b1) begin n_fail++; $display("FAIL ld_w_reg_wen[%0d]: got %b want 1", k, o_w_reg_wen); end
            n_checks++; if (o_w_exc !== 1'b0) begin n_fail++; $display("FAIL ld_w_exc[%0d]: got %b want 0", k, o_w_exc); end
            tick();
            n_checks++; if (o_w_valid !== 1'b0) begin n_fail++; $display("FAIL ld_retire[%0d]: got %b want 0", k, o_w_valid); end
        end
    endtask

    task automatic test_store;
        logic [31:0] addrs [2];
        logic [2:0]  types [2];
        logic [31:0] rs2s  [2];
        int          waits [2];
        logic [31:0] wdat  [2];
        logic [3:0]  mask  [2];
        logic [31:0] baddr [2];
        addrs[0] = 32'h201; types[0] = 3'b000; rs2s[0] = 32'h0000_00AB; waits[0] = 2;
        wdat[0] = 32'hABAB_ABAB; mask[0] = 4'b0010; baddr[0] = 32'h200;
        addrs[1] = 32'h302; types[1] = 3'b001; rs2s[1] = 32'h1234_CDEF; waits[1] = 0;
        wdat[1] = 32'hCDEF_CDEF; mask[1] = 4'b1100; baddr[1] = 32'h300;
        for (int k = 0; k < 2; k++) begin
            drive_op(1'b0, 1'b1, types[k], addrs[k], rs2s[k], 32'd0, 5'd7);
            tick();
            drop_op();
            for (int c = 0; c <= waits[k]; c++) begin
                n_checks++; if (o_bus_req !== 1'b1) begin n_fail++; $display("FAIL st_bus_req[%0d.%0d]: got %b want 1", k, c, o_bus_req); end
                n_checks++; if (o_bus_we !== 1'b1) begin n_fail++; $display("FAIL st_bus_we[%0d.%0d]: got %b want 1", k, c, o_bus_we); end
                n_checks++; if (o_bus_wdata !== wdat[k]) begin n_fail++; $display("FAIL st_wdata[%0d.%0d]: got %h want %h", k, c, o_bus_wdata, wdat[k]); end
                n_checks++; if (o_bus_bytemask !== mask[k]) begin n_fail++; $display("FAIL st_mask[%0d.%0d]: got %b want %b", k, c, o_bus_bytemask, mask[k]); end
                n_checks++; if (o_bus_addr !== baddr[k]) begin n_fail++; $display("FAIL st_addr[%0d.%0d]: got %h want %h", k, c, o_bus_addr, baddr[k]); end
                if (c == waits[k]) i_bus_gnt = 1'b1;
                tick();
            end
            i_bus_gnt = 1'b0;
            n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL st_req_drop[%0d]: got %b want 0", k, o_bus_req); end
            n_checks++; if (o_w_valid !== 1'b1) begin n_fail++; $display("FAIL st_w_valid[%0d]: got %b want 1", k, o_w_valid); end
            n_checks++; if (o_w_reg_wen !== 1'b0) begin n_fail++; $display("FAIL st_reg_wen[%0d]: got %b want 0", k, o_w_reg_wen); end
            n_checks++; if (o_w_exc !== 1'b0) begin n_fail++; $display("FAIL st_w_exc[%0d]: got %b want 0", k, o_w_exc); end
            tick();
            n_checks++; if (o_w_valid !== 1'b0) begin n_fail++; $display("FAIL st_retire[%0d]: got %b want 0", k, o_w_valid); end
        end
    endtask

    task automatic test_misaligned;
        logic        wens  [2];
        logic [2:0]  types [2];
        logic [31:0] addrs [2];
        logic [3:0]  cause [2];
        wens[0] = 1'b0; types[0] = 3'b010; addrs[0] = 32'h6; cause[0] = 4'd4;
        wens[1] = 1'b1; types[1] = 3'b001; addrs[1] = 32'h5; cause[1] = 4'd6;
        for (int k = 0; k < 2; k++) begin
            drive_op(~wens[k], wens[k], types[k], addrs[k], 32'h5555_5555, 32'd0, 5'd3);
            tick();
            drop_op();
            n_checks++; if (o_w_valid !== 1'b1) begin n_fail++; $display("FAIL mis_w_valid[%0d]: got %b want 1", k, o_w_valid); end
            n_checks++; if (o_w_exc !== 1'b1) begin n_fail++; $display("FAIL mis_w_exc[%0d]: got %b want 1", k, o_w_exc); end
            n_checks++; if (o_w_cause !== cause[k]) begin n_fail++; $display("FAIL mis_cause[%0d]: got %0d want %0d", k, o_w_cause, cause[k]); end
            n_checks++; if (o_w_badaddr !== addrs[k]) begin n_fail++; $display("FAIL mis_badaddr[%0d]: got %h want %h", k, o_w_badaddr, addrs[k]); end
            n_checks++; if (o_w_reg_wen !== 1'b0) begin n_fail++; $display("FAIL mis_reg_wen[%0d]: got %b want 0", k, o_w_reg_wen); end
            n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL mis_bus_req[%0d]: got %b want 0", k, o_bus_req); end
            tick();
            n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL mis_no_req[%0d]: got %b want 0", k, o_bus_req); end
        end
    endtask

    task automatic test_timeout;
        drive_op(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 32'd0, 5'd3);
        tick();
        drop_op();
        i_bus_gnt = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        i_w_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_checks++; if (o_w_valid !== 1'b0) begin n_fail++; $display("FAIL to_wait[%0d]: got %b want 0", c, o_w_valid); end
            tick();
        end
        n_checks++; if (o_w_valid !== 1'b1) begin n_fail++; $display("FAIL to_w_valid: got %b want 1", o_w_valid); end
        n_checks++; if (o_w_exc !== 1'b1) begin n_fail++; $display("FAIL to_w_exc: got %b want 1", o_w_exc); end
        n_checks++; if (o_w_cause !== 4'd5) begin n_fail++; $display("FAIL to_cause: got %0d want 5", o_w_cause); end
        n_checks++; if (o_w_badaddr !== 32'h400) begin n_fail++; $display("FAIL to_badaddr: got %h want 400", o_w_badaddr); end
        n_checks++; if (o_w_reg_wen !== 1'b0) begin n_fail++; $display("FAIL to_reg_wen: got %b want 0", o_w_reg_wen); end
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1234_5678;
        tick();
        i_bus_rvalid = 1'b0;
        n_checks++; if (o_w_cause !== 4'd5) begin n_fail++; $display("FAIL to_late_cause: got %0d want 5", o_w_cause); end
        n_checks++; if (o_w_data !== 32'd0) begin n_fail++; $display("FAIL to_late_data: got %h want 0", o_w_data); end
        n_checks++; if (o_w_valid !== 1'b1) begin n_fail++; $display("FAIL to_late_valid: got %b want 1", o_w_valid); end
        i_w_ready = 1'b1;
        tick();
        n_checks++; if (o_w_valid !== 1'b0) begin n_fail++; $display("FAIL to_retire: got %b want 0", o_w_valid); end
    endtask

    task automatic test_flush;
        // flush while waiting for load response
        drive_op(1'b1, 1'b0, 3'b000, 32'h104, 32'd0, 32'd0, 5'd4);
        tick();
        drop_op();
        i_bus_gnt = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        i_flush = 1'b1;
        #1;
        n_checks++; if (o_m_ready_c !== 1'b0) begin n_fail++; $display("FAIL fl_m_ready: got %b want 0", o_m_ready_c); end
        tick();
        i_flush = 1'b0;
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h0000_00FF;
        tick();
        i_bus_rvalid = 1'b0;
        n_checks++; if (o_w_valid !== 1'b0) begin n_fail++; $display("FAIL fl_dead_valid: got %b want 0", o_w_valid); end
        n_checks++; if (o_m_ready_c !== 1'b1) begin n_fail++; $display("FAIL fl_idle: got %b want 1", o_m_ready_c); end
        // following load completes normally
        drive_op(1'b1, 1'b0, 3'b000, 32'h105, 32'd0, 32'd0, 5'd6);
        tick();
        drop_op();
        i_bus_gnt = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h0000_7F00;
        tick();
        i_bus_rvalid = 1'b0;
        n_checks++; if (o_w_valid !== 1'b1) begin n_fail++; $display("FAIL fl_next_valid: got %b want 1", o_w_valid); end
        n_checks++; if (o_w_data !== 32'h0000_007F) begin n_fail++; $display("FAIL fl_next_data: got %h want 0000007f", o_w_data); end
        tick();
        // flush during store request: request held until grant, result dropped
        drive_op(1'b0, 1'b1, 3'b010, 32'h500, 32'hDEAD_BEEF, 32'd0, 5'd2);
        tick();
        drop_op();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n_checks++; if (o_bus_req !== 1'b1) begin n_fail++; $display("FAIL fl_st_req_held: got %b want 1", o_bus_req); end
        i_bus_gnt = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL fl_st_req_drop: got %b want 0", o_bus_req); end
        n_checks++; if (o_w_valid !== 1'b0) begin n_fail++; $display("FAIL fl_st_valid: got %b want 0", o_w_valid); end
        // flush in HOLD with writeback stalled
        i_w_ready = 1'b0;
        drive_op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h0BAD_CAFE, 5'd8);
        tick();
        drop_op();
        tick();
        n_checks++; if (o_w_valid !== 1'b1) begin n_fail++; $display("FAIL fl_hold_valid: got %b want 1", o_w_valid); end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n_checks++; if (o_w_valid !== 1'b0) begin n_fail++; $display("FAIL fl_hold_drop: got %b want 0", o_w_valid); end
        i_w_ready = 1'b1;
    endtask

    task automatic test_reset_mid_access;
        drive_op(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 32'd0, 5'd1);
        tick();
        drop_op();
        n_checks++; if (o_bus_req !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %b want 1", o_bus_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_clear: got %b want 0", o_bus_req); end
        n_checks++; if (o_m_ready_c !== 1'b1) begin n_fail++; $display("FAIL rm_idle: got %b want 1", o_m_ready_c); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_flush();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
